// File: rtl/move_issue_v_if.sv
// Move request / result bus between the move source (engine or UI) and move_issue_v.
//   master : the move source; drives req_valid/req_from/req_to/player, sees ready and results
//   slave  : move_issue_v; drives req_ready and the rsp_* result strobe
interface move_issue_v_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_from;
  logic [5:0] req_to;
  logic       player;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [3:0] rsp_piece;
  logic       rsp_capture;

  modport master (
    output req_valid, req_from, req_to, player,
    input  req_ready, rsp_valid, rsp_status, rsp_piece, rsp_capture
  );

  modport slave (
    input  req_valid, req_from, req_to, player,
    output req_ready, rsp_valid, rsp_status, rsp_piece, rsp_capture
  );
endinterface

// File: rtl/move_issue_v.sv
// move_issue_v: resolves a from/to move request into a board-updater transaction.
//
// Scans all 16 pieces of the side to move (index 15 down to 0) to find the live piece on the
// from-square, checks the to-square for an own piece (blocked) and, optionally, for a live
// opponent piece (capture). Legal moves strobe upd_en and wait for upd_done, giving up after
// TIMEOUT cycles. Every request ends with a one-cycle rsp_valid strobe.
//
// Ports:
//   clk, RST            clock, synchronous active-low reset
//   bus (slave)         req_valid/req_ready/req_from/req_to/player, rsp_valid/status/piece/capture
//   location_vectors_*  piece k square at bits [6k+5:6k]; alive_vectors_* bit k = piece k alive
//   upd_en/upd_piece_number/upd_move/upd_player  updater handshake, upd_done completion pulse
//   busy                high whenever not idle
//
// Build option: define MOVE_ISSUE_CAPTURE_EN to compare opponent pieces and report rsp_capture;
// otherwise rsp_capture is constant 0.
module move_issue_v #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          RST,
  move_issue_v_if.slave bus,
  input  logic [95:0]   location_vectors_w,
  input  logic [95:0]   location_vectors_b,
  input  logic [15:0]   alive_vectors_w,
  input  logic [15:0]   alive_vectors_b,
  output logic          upd_en,
  output logic [3:0]    upd_piece_number,
  output logic [5:0]    upd_move,
  output logic          upd_player,
  input  logic          upd_done,
  output logic          busy
);

  typedef enum logic [2:0] {StIdle, StScan, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusNoPiece = 2'b01;
  localparam logic [1:0] StatusBlocked = 2'b10;
  localparam logic [1:0] StatusTimeout = 2'b11;
  localparam logic [7:0] WaitLast      = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [5:0] from_q, to_q;
  logic       player_q;
  logic [3:0] scan_k_q;
  logic       found_q, blocked_q, capture_q;
  logic [3:0] piece_q;
  logic [7:0] wait_cnt_q;

  logic       req_ready_q, busy_q;
  logic       upd_en_q, upd_player_q;
  logic [3:0] upd_piece_q;
  logic [5:0] upd_move_q;
  logic       rsp_valid_q, rsp_capture_q;
  logic [1:0] rsp_status_q;
  logic [3:0] rsp_piece_q;

  // Per-piece view of the packed board vectors.
  logic [5:0] loc_w [16];
  logic [5:0] loc_b [16];

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      loc_w[k] = location_vectors_w[6*k +: 6];
      loc_b[k] = location_vectors_b[6*k +: 6];
    end
  end

  logic [5:0] own_loc;
  logic       own_alive, hit_from, hit_to, cap_hit;
  logic       found_nx, blocked_nx, capture_nx;
  logic [3:0] piece_nx;

  always_comb begin
    own_loc   = player_q ? loc_w[scan_k_q] : loc_b[scan_k_q];
    own_alive = player_q ? alive_vectors_w[scan_k_q] : alive_vectors_b[scan_k_q];
    hit_from  = own_alive && (own_loc == from_q);
    hit_to    = own_alive && (own_loc == to_q);
  end

`ifdef MOVE_ISSUE_CAPTURE_EN
  logic [5:0] opp_loc;
  logic       opp_alive;

  always_comb begin
    opp_loc   = player_q ? loc_b[scan_k_q] : loc_w[scan_k_q];
    opp_alive = player_q ? alive_vectors_b[scan_k_q] : alive_vectors_w[scan_k_q];
    cap_hit   = opp_alive && (opp_loc == to_q);
  end
`else
  always_comb cap_hit = 1'b0;
`endif

  // Flags including the piece under test this cycle; used for the final decision at k = 0.
  always_comb begin
    found_nx   = found_q | hit_from;
    blocked_nx = blocked_q | hit_to;
    capture_nx = capture_q | cap_hit;
    // First match wins, and the scan runs from 15 downward.
    piece_nx   = (hit_from && !found_q) ? scan_k_q : piece_q;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q       <= StIdle;
      from_q        <= '0;
      to_q          <= '0;
      player_q      <= 1'b1;
      scan_k_q      <= '0;
      found_q       <= 1'b0;
      blocked_q     <= 1'b0;
      capture_q     <= 1'b0;
      piece_q       <= '0;
      wait_cnt_q    <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      upd_en_q      <= 1'b0;
      upd_piece_q   <= '0;
      upd_move_q    <= '0;
      upd_player_q  <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= StatusOk;
      rsp_piece_q   <= '0;
      rsp_capture_q <= 1'b0;
    end else begin
      // Both strobes last exactly one cycle.
      upd_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            from_q      <= bus.req_from;
            to_q        <= bus.req_to;
            player_q    <= bus.player;
            found_q     <= 1'b0;
            blocked_q   <= 1'b0;
            capture_q   <= 1'b0;
            piece_q     <= '0;
            scan_k_q    <= 4'd15;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StScan;
          end
        end
        StScan: begin
          found_q   <= found_nx;
          blocked_q <= blocked_nx;
          capture_q <= capture_nx;
          piece_q   <= piece_nx;
          scan_k_q  <= scan_k_q - 4'd1;
          if (scan_k_q == 4'd0) begin
            if (!found_nx) begin
              rsp_valid_q   <= 1'b1;
              rsp_status_q  <= StatusNoPiece;
              rsp_piece_q   <= '0;
              rsp_capture_q <= capture_nx;
              state_q       <= StResp;
            end else if (blocked_nx) begin
              rsp_valid_q   <= 1'b1;
              rsp_status_q  <= StatusBlocked;
              rsp_piece_q   <= piece_nx;
              rsp_capture_q <= capture_nx;
              state_q       <= StResp;
            end else begin
              upd_en_q     <= 1'b1;
              upd_piece_q  <= piece_nx;
              upd_move_q   <= to_q;
              upd_player_q <= player_q;
              state_q      <= StIssue;
            end
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // upd_done beats the timeout when both land in the same cycle.
          if (upd_done || (wait_cnt_q == WaitLast)) begin
            rsp_valid_q   <= 1'b1;
            rsp_status_q  <= upd_done ? StatusOk : StatusTimeout;
            rsp_piece_q   <= piece_q;
            rsp_capture_q <= capture_q;
            state_q       <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StResp: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_status   = rsp_status_q;
  assign bus.rsp_piece    = rsp_piece_q;
  assign bus.rsp_capture  = rsp_capture_q;
  assign upd_en           = upd_en_q;
  assign upd_piece_number = upd_piece_q;
  assign upd_move         = upd_move_q;
  assign upd_player       = upd_player_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_move_issue_v.sv
// Scoreboard bench for move_issue_v: the driver pushes expected updater strobes and results,
// a negedge monitor pops and compares them whenever upd_en or rsp_valid is seen.
module tb_move_issue_v;

`ifdef MOVE_ISSUE_CAPTURE_EN
  localparam bit CapEn = 1'b1;
`else
  localparam bit CapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_issue_v_if bus ();

  logic [95:0] lv_w, lv_b;
  logic [15:0] av_w, av_b;
  logic [5:0]  loc_w [16];
  logic [5:0]  loc_b [16];
  logic        upd_en, upd_player, upd_done, busy;
  logic [3:0]  upd_piece_number;
  logic [5:0]  upd_move;

  always_comb begin
    lv_w = '0;
    lv_b = '0;
    for (int k = 0; k < 16; k++) begin
      lv_w[6*k +: 6] = loc_w[k];
      lv_b[6*k +: 6] = loc_b[k];
    end
  end

  move_issue_v #(.TIMEOUT(15)) dut (
    .clk                (clk),
    .RST                (rst_n),
    .bus                (bus),
    .location_vectors_w (lv_w),
    .location_vectors_b (lv_b),
    .alive_vectors_w    (av_w),
    .alive_vectors_b    (av_b),
    .upd_en             (upd_en),
    .upd_piece_number   (upd_piece_number),
    .upd_move           (upd_move),
    .upd_player         (upd_player),
    .upd_done           (upd_done),
    .busy               (busy)
  );

  typedef struct {logic [1:0] status; logic [3:0] piece; logic cap; int cyc;} rsp_t;
  typedef struct {logic [3:0] piece; logic [5:0] move; logic player; int cyc;} upd_t;

  rsp_t rsp_q [$];
  upd_t upd_q [$];
  rsp_t re;
  upd_t ue;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   upd_cnt = 0;
  int   done_delay = -1;
  logic rsp_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_prev) begin
        chk("ready_after_rsp", int'(bus.req_ready), 1);
        chk("idle_after_rsp", int'(busy), 0);
      end
      if (upd_en) begin
        upd_cnt++;
        if (upd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_upd_en: got piece %0d, expected no strobe", upd_piece_number);
        end else begin
          ue = upd_q.pop_front();
          chk("upd_cycle", cyc, ue.cyc);
          chk("upd_piece", int'(upd_piece_number), int'(ue.piece));
          chk("upd_move", int'(upd_move), int'(ue.move));
          chk("upd_player", int'(upd_player), int'(ue.player));
        end
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got status %0d, expected no strobe", bus.rsp_status);
        end else begin
          re = rsp_q.pop_front();
          chk("rsp_cycle", cyc, re.cyc);
          chk("rsp_status", int'(bus.rsp_status), int'(re.status));
          chk("rsp_piece", int'(bus.rsp_piece), int'(re.piece));
          chk("rsp_capture", int'(bus.rsp_capture), int'(re.cap));
        end
      end
      rsp_prev = bus.rsp_valid;
    end else begin
      rsp_prev = 1'b0;
    end
  end

  // Updater model: answers upd_en with a one-cycle upd_done done_delay cycles later (<=0: never).
  initial begin
    upd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && upd_en && done_delay > 0) begin
        repeat (done_delay) @(posedge clk);
        #1 upd_done = 1'b1;
        @(posedge clk);
        #1 upd_done = 1'b0;
      end
    end
  end

  task automatic set_initial_board();
    for (int k = 8; k < 16; k++) begin
      loc_w[k] = 6'(23 - k);  // P1 (k=15) on 8 .. P8 (k=8) on 15
      loc_b[k] = 6'(63 - k);  // P1 on 48 .. P8 on 55
    end
    loc_w[7] = 6'd0;  loc_w[6] = 6'd7;  loc_w[5] = 6'd1;  loc_w[4] = 6'd6;
    loc_w[3] = 6'd2;  loc_w[2] = 6'd5;  loc_w[1] = 6'd3;  loc_w[0] = 6'd4;
    loc_b[7] = 6'd56; loc_b[6] = 6'd63; loc_b[5] = 6'd57; loc_b[4] = 6'd62;
    loc_b[3] = 6'd58; loc_b[2] = 6'd61; loc_b[1] = 6'd59; loc_b[0] = 6'd60;
    av_w = 16'hFFFF;
    av_b = 16'hFFFF;
  endtask

  task automatic issue_req(input logic pl, input int from, input int to, output int t);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_from  = 6'(from);
    bus.req_to    = 6'(to);
    bus.player    = pl;
    t = cyc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // legal: an updater strobe is expected; delay <= 0 means the updater never answers.
  task automatic do_move(input logic pl, input int from, input int to, input int delay,
                         input bit legal, input logic [1:0] st, input int piece, input bit cap);
    int t;
    int start;
    int rcyc;
    done_delay = delay;
    start = rsp_cnt;
    issue_req(pl, from, to, t);
    if (!legal)        rcyc = t + 17;
    else if (delay > 0) rcyc = t + 18 + delay;
    else               rcyc = t + 18 + 15;
    if (legal) upd_q.push_back('{4'(piece), 6'(to), pl, t + 17});
    rsp_q.push_back('{st, 4'(piece), cap, rcyc});
    @(negedge clk);
    chk("busy_in_scan", int'(busy), 1);
    chk("ready_in_scan", int'(bus.req_ready), 0);
    for (int i = 0; i < 80 && rsp_cnt == start; i++) @(negedge clk);
    if (rsp_cnt == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_wait: got no rsp_valid, expected one by cycle %0d", rcyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_upd_en"}, int'(upd_en), 0);
    chk({tag, "_upd_piece"}, int'(upd_piece_number), 0);
    chk({tag, "_upd_move"}, int'(upd_move), 0);
    chk({tag, "_upd_player"}, int'(upd_player), 1);
    chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({tag, "_rsp_status"}, int'(bus.rsp_status), 0);
    chk({tag, "_rsp_piece"}, int'(bus.rsp_piece), 0);
    chk({tag, "_rsp_capture"}, int'(bus.rsp_capture), 0);
  endtask

  initial begin
    int t;
    bus.req_valid = 1'b0;
    bus.req_from  = '0;
    bus.req_to    = '0;
    bus.player    = 1'b1;
    set_initial_board();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Legal pawn push, then empty square and dead piece
    do_move(1'b1, 12, 28, 2, 1'b1, 2'b00, 11, 1'b0);
    do_move(1'b1, 20, 28, 2, 1'b0, 2'b01, 0, 1'b0);
    av_w[11] = 1'b0;
    do_move(1'b1, 12, 28, 2, 1'b0, 2'b01, 0, 1'b0);
    av_w[11] = 1'b1;
    // Own-piece blocks, including from == to
    do_move(1'b1, 1, 11, 2, 1'b0, 2'b10, 5, 1'b0);
    do_move(1'b1, 12, 12, 2, 1'b0, 2'b10, 11, 1'b0);
    // Capture of black P1
    do_move(1'b1, 8, 48, 1, 1'b1, 2'b00, 15, CapEn);
    // Black legal move and updater timeout
    do_move(1'b0, 55, 47, 3, 1'b1, 2'b00, 8, 1'b0);
    do_move(1'b0, 60, 44, -1, 1'b1, 2'b11, 0, 1'b0);

    // Reset during WAIT: the updater strobe happens, no result follows
    done_delay = -1;
    issue_req(1'b0, 60, 44, t);
    upd_q.push_back('{4'd0, 6'd44, 1'b0, t + 17});
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("wait_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_wait_rst", int'(bus.req_ready), 1);

    // Reset mid-SCAN: neither upd_en nor rsp_valid may appear afterwards
    done_delay = 2;
    issue_req(1'b1, 12, 28, t);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_after_scan_rst", int'(busy), 0);

    // Normal operation resumes
    do_move(1'b1, 12, 28, 2, 1'b1, 2'b00, 11, 1'b0);

    chk("upd_queue_drained", upd_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/move_issue_v.md
# move_issue_v

Initiator-side companion to the board updater: accepts a from-square/to-square move request from the engine or UI and resolves which live piece of the side to move sits on the from-square. It checks the target for own-piece blocking and detects captures, then drives the updater's `en`/`piece_number`/`move_input` handshake and waits for its `done` pulse. It sits between the move source and the board updater and reads the same location and alive vectors the updater publishes.

## Interface
- `TIMEOUT`, 15: cycles to wait for `upd_done` before aborting (1..255).
- `clk`  in  1  system clock
- `RST`  in  1  synchronous, active-low reset
- `req_valid`  in  1  move request present
- `req_ready`  out  1  high only in IDLE
- `req_from`  in  6  source square 0..63
- `req_to`  in  6  destination square 0..63
- `player`  in  1  side to move (1 = white, 0 = black); latched on accept
- `location_vectors_w` / `location_vectors_b`  in  96 each  piece k at bits [6k+5:6k], k = 15 (P1) .. 0 (K1)
- `alive_vectors_w` / `alive_vectors_b`  in  16 each  bit k = piece k alive
- `upd_en`  out  1  one-cycle strobe to the updater
- `upd_piece_number`  out  4  selected piece index
- `upd_move`  out  6  destination square
- `upd_player`  out  1  latched player
- `upd_done`  in  1  updater completion pulse
- `rsp_valid`  out  1  one-cycle result strobe
- `rsp_status`  out  2  00 ok, 01 no own piece at from, 10 blocked by own piece at to, 11 updater timeout
- `rsp_piece`  out  4  selected piece index; 0 when status is 01
- `rsp_capture`  out  1  live opponent piece occupied `req_to`
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SCAN, ISSUE, WAIT, RESP.
- IDLE: `req_ready` = 1.
  - On `req_valid`, latch `req_from`, `req_to` and `player`.
  - Clear the found, blocked and capture flags, load the 4-bit scan counter with 15, go to SCAN.
- SCAN: one piece index k per cycle, from 15 down to 0; always all 16 cycles, no early exit.
  - Own side = side selected by the latched `player`.
  - Found: own piece k alive, location == from, and none found yet. Record k, so the highest matching index wins.
  - Blocked: own piece k alive with location == to. from == to therefore always yields status 10.
  - Capture: opponent piece k alive with location == to.
  - Dead pieces are ignored for every check.
- After k = 0, the counter wraps with no side effect and the state is chosen by priority:
  - not found → RESP, status 01
  - blocked → RESP, status 10
  - otherwise → ISSUE
- ISSUE: for one cycle, `upd_en` = 1, `upd_piece_number` = k, `upd_move` = to, `upd_player` = latched player. Clear the timeout counter, go to WAIT.
- WAIT: `upd_en` = 0.
  - `upd_done` = 1 → RESP, status 00.
  - Timeout counter reaches `TIMEOUT` → RESP, status 11.
  - A `upd_done` seen in the same cycle as the timeout takes precedence (status 00).
- RESP: `rsp_valid` = 1 for one cycle with status, piece and capture → IDLE.
- `rsp_*`, `upd_piece_number`, `upd_move` and `upd_player` hold their last values between strobes.
- Board vectors are read live during SCAN. The source must not change them while `busy` = 1.
- `req_valid` outside IDLE is ignored; there is no queueing.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `req_ready` 1, `busy` 0, `upd_en` 0, `upd_piece_number` 0, `upd_move` 0, `upd_player` 1, `rsp_valid` 0, `rsp_status` 00, `rsp_piece` 0, `rsp_capture` 0.
- Accept in cycle T. SCAN occupies T+1..T+16.
- Rejected move: `rsp_valid` at T+17.
- Legal move: `upd_en` at T+17. If `upd_done` is first seen at cycle D, `rsp_valid` is at D+1. `req_ready` returns at D+2.
- Timeout: `rsp_valid` at T+18+`TIMEOUT`.
- `RST` = 0 in any state, including mid-SCAN or WAIT: return to IDLE with reset values next edge. No pending `upd_en` is emitted.

## Configuration
- `MOVE_ISSUE_CAPTURE_EN` defined: opponent vectors are compared during SCAN and `rsp_capture` reports the result.
- Undefined: opponent comparators are removed, `rsp_capture` is tied 0, all other behaviour is unchanged.

## Test plan
Initial position: white P1..P8 = 8..15, R1 = 0, R2 = 7, N1 = 1, N2 = 6, B1 = 2, B2 = 5, Q1 = 3, K1 = 4; black P1..P8 = 48..55, K1 = 60; all alive.
- Legal move: white, from 12 to 28, `upd_done` returned 2 cycles after `upd_en` → `upd_en` at T+17 with piece 11 (P5), move 28, player 1; `rsp_status` 00, `rsp_piece` 11, `rsp_capture` 0.
- Empty square: white, from 20 → `rsp_status` 01 at T+17, `upd_en` never asserted. Repeat from 12 with `alive_vectors_w[11]` = 0 → status 01.
- Own-piece block: white, from 1 to 11 → status 10, `rsp_piece` 5. White, from 12 to 12 → status 10.
- Capture: white, from 8 to 48 → status 00, piece 15, `rsp_capture` 1 with the macro defined; 0 without it.
- Timeout and reset:
  - Black, from 60 to 44 with `upd_done` held 0 → status 11, piece 0, `rsp_valid` at T+33.
  - Repeat, assert `RST` = 0 during WAIT → all outputs at reset values next cycle; `req_ready` = 1 after release.
